// File: rtl/hisoc_boot_pkg.sv
// hisoc_boot_pkg: shared boot loader states, frame constants and state helper
package hisoc_boot_pkg;
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
    S_CHECK  = 3'd4,
    S_DONE   = 3'd5,
    S_ERROR  = 3'd6
  } state_t;
  localparam int HDR_BYTES  = 2;
  localparam int WORD_BYTES = 4;
  function automatic logic is_active(input state_t s);
    return s == S_LEN_LO || s == S_LEN_HI || s == S_DATA || s == S_CHECK;
  endfunction
endpackage

// File: rtl/hisoc_boot_pack.sv
// hisoc_boot_pack: little-endian byte-to-word packer with a one-cycle word-valid pulse
module hisoc_boot_pack
  import hisoc_boot_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  data,
  output logic        last,
  output logic [31:0] word,
  output logic        word_valid
);
  logic [1:0] cnt;
  assign last = en && cnt == 2'(WORD_BYTES - 1);
  // shift new bytes in from the top so byte 0 ends up in bits 7:0
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt        <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= last;
      if (en) begin
        cnt  <= cnt + 2'd1;
        word <= {data, word[31:8]};
      end
    end
  end
endmodule

// File: rtl/hisoc_boot_loader.sv
// hisoc_boot_loader: host byte stream to instruction memory loader; BOOT_CHECKSUM_EN adds a trailing XOR check byte
module hisoc_boot_loader
  import hisoc_boot_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  s_valid,
  input  logic [7:0]            s_data,
  output logic                  s_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  core_enable,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
`ifdef BOOT_CHECKSUM_EN
  localparam state_t FIN = S_CHECK;
  logic [7:0] csum;
`else
  localparam state_t FIN = S_DONE;
`endif
  state_t state, nxt;
  logic [15:0] len, n_hdr;
  logic [ADDR_WIDTH:0] idx;
  logic acc, go, pack_en, last, final_word;
  assign acc        = s_valid && s_ready;
  assign go         = start && (state == S_IDLE || state == S_DONE || state == S_ERROR);
  assign pack_en    = acc && state == S_DATA;
  assign n_hdr      = {s_data, len[7:0]};
  assign final_word = last && (17'(idx) + 17'd1 == 17'(len));
  hisoc_boot_pack u_pack (
    .clk        (clk),
    .rst        (rst),
    .clr        (go),
    .en         (pack_en),
    .data       (s_data),
    .last       (last),
    .word       (mem_wdata),
    .word_valid (mem_we)
  );
  // next-state decode; start only matters in the resting states
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE, S_DONE, S_ERROR: nxt = start ? S_LEN_LO : state;
      S_LEN_LO: nxt = acc ? S_LEN_HI : state;
      S_LEN_HI: nxt = !acc ? state : n_hdr == 16'd0 ? FIN : 32'(n_hdr) > DEPTH ? S_ERROR : S_DATA;
      S_DATA:   nxt = final_word ? FIN : state;
`ifdef BOOT_CHECKSUM_EN
      S_CHECK:  nxt = !acc ? state : s_data == csum ? S_DONE : S_ERROR;
`endif
      default:  nxt = S_IDLE;
    endcase
  end
  // state, registered status outputs, header length, word index and checksum
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      s_ready     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      core_enable <= 1'b0;
      mem_addr    <= '0;
      idx         <= '0;
      len         <= '0;
`ifdef BOOT_CHECKSUM_EN
      csum        <= '0;
`endif
    end else begin
      state       <= nxt;
      s_ready     <= is_active(nxt);
      busy        <= is_active(nxt);
      done        <= nxt == S_DONE;
      error       <= nxt == S_ERROR;
      core_enable <= nxt == S_DONE;
      if (go) begin
        idx <= '0;
        len <= '0;
      end
      if (acc && state == S_LEN_LO) len[7:0] <= s_data;
      if (acc && state == S_LEN_HI) len[15:8] <= s_data;
      if (last) begin
        mem_addr <= idx[ADDR_WIDTH-1:0];
        idx      <= idx + 1'b1;
      end
`ifdef BOOT_CHECKSUM_EN
      if (go) csum <= '0;
      else if (pack_en) csum <= csum ^ s_data;
`endif
    end
  end
endmodule

// File: tb/tb_hisoc_boot_loader.sv
// tb_hisoc_boot_loader: directed scoreboard bench for hisoc_boot_loader (ADDR_WIDTH=4)
module tb_hisoc_boot_loader;
  logic clk = 1'b0, rst, start, s_valid;
  logic [7:0] s_data;
  logic s_ready, mem_we, core_enable, busy, done, error;
  logic [3:0] mem_addr;
  logic [31:0] mem_wdata;
  int total = 0, bad = 0, cyc = 0, nwe = 0;
  logic [35:0] sb [$];
  int wc [$];
  logic [31:0] wbuf [16];

  hisoc_boot_loader #(.ADDR_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_enable(core_enable), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [35:0] e;
    if (mem_we === 1'b1) begin
      nwe++;
      wc.push_back(cyc);
      e = sb.size() != 0 ? sb.pop_front() : 36'bx;
      chk("mem_write", {28'd0, mem_addr, mem_wdata}, {28'd0, e});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic r;
    r = 1'b0;
    s_valid = 1'b1;
    s_data = b;
    for (int k = 0; k < 20 && !r; k++) begin
      r = s_ready;
      tick();
    end
    chk("byte_accept", r, 1);
  endtask

  task automatic boot(input int n, input bit ok, input bit gap);
    logic [7:0] cs, b;
    logic [15:0] nn;
    logic fin_ok;
    int nwe0;
    nn = 16'(n);
    cs = 8'd0;
    wc.delete();
    nwe0 = nwe;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ready_rise", s_ready, 1);
    send_byte(nn[7:0]);
    send_byte(nn[15:8]);
    if (n > 16) begin
      s_valid = 1'b0;
      chk("oversize_error", error, 1);
      chk("oversize_ready", s_ready, 0);
      repeat (3) tick();
      chk("oversize_no_we", nwe - nwe0, 0);
      return;
    end
    for (int i = 0; i < n; i++) sb.push_back({4'(i), wbuf[i]});
    for (int i = 0; i < n; i++)
      for (int j = 0; j < 4; j++) begin
        b = wbuf[i][8*j +: 8];
        cs ^= b;
        send_byte(b);
        if (gap) begin
          s_valid = 1'b0;
          start = (i == 1 && j == 0);
          tick();
          start = 1'b0;
          if (i == 1 && j == 0) chk("busy_hold", busy, 1);
        end
      end
`ifdef BOOT_CHECKSUM_EN
    send_byte(ok ? cs : cs ^ 8'hFF);
    fin_ok = ok;
`else
    fin_ok = 1'b1;
`endif
    s_valid = 1'b0;
    chk("done", done, fin_ok);
    chk("error", error, !fin_ok);
    chk("core_enable", core_enable, fin_ok);
    chk("ready_fall", s_ready, 0);
    repeat (3) tick();
    chk("sb_drain", sb.size(), 0);
    chk("we_count", nwe - nwe0, n);
    for (int k = 1; k < wc.size(); k++) chk("we_spacing", wc[k] - wc[k-1], gap ? 8 : 4);
  endtask

  initial begin
    int nwe0;
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = 8'd0;
    repeat (3) tick();
    chk("reset_outputs", {s_ready, mem_we, mem_addr, mem_wdata, core_enable, busy, done, error}, 0);
    rst = 1'b0;
    tick();
    wbuf[0] = 32'h0000_0013; wbuf[1] = 32'h0000_006F;
    boot(2, 1, 0);
`ifdef BOOT_CHECKSUM_EN
    boot(2, 0, 0);
`endif
    boot(0, 1, 0);
    boot(17, 1, 0);
    for (int i = 0; i < 16; i++) wbuf[i] = 32'h1357_9BDF * (i + 1) ^ 32'(i << 24);
    boot(16, 1, 0);
    wbuf[0] = 32'hDEAD_BEEF; wbuf[1] = 32'h0123_4567; wbuf[2] = 32'hA5C3_0F81;
    boot(3, 1, 1);
    nwe0 = nwe;
    start = 1'b1;
    tick();
    start = 1'b0;
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h13); send_byte(8'h00);
    s_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk("midreset_outputs", {s_ready, mem_we, mem_addr, mem_wdata, core_enable, busy, done, error}, 0);
    repeat (2) tick();
    rst = 1'b0;
    tick();
    chk("midreset_idle", {s_ready, busy, done, error, core_enable}, 0);
    chk("midreset_no_we", nwe - nwe0, 0);
    wbuf[0] = 32'h0000_0013; wbuf[1] = 32'h0000_006F;
    boot(2, 1, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hisoc_boot_loader.md
# hisoc_boot_loader

Instruction-memory boot loader sitting directly upstream of the HISOC instruction memory. It accepts a byte stream from a host link (valid/ready), assembles little-endian 32-bit words, writes them sequentially into the instruction memory write port, and only then asserts the core enable. This replaces the simulation-only memory preload with a synthesizable path the bench and the FPGA flow share.

## Interface
- ADDR_WIDTH, 10: instruction memory word-address width; depth = 2**ADDR_WIDTH words.
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a boot session; sampled only in IDLE, DONE or ERROR.
- s_valid  input  1  host byte valid.
- s_data  input  8  host byte.
- s_ready  output  1  loader accepts a byte this cycle.
- mem_we  output  1  instruction memory write strobe, one cycle per word.
- mem_addr  output  ADDR_WIDTH  word address of the write.
- mem_wdata  output  32  word written.
- core_enable  output  1  releases the core; drives HISOC enable.
- busy  output  1  session in progress.
- done  output  1  last session completed successfully.
- error  output  1  last session failed.

## Operation
- Frame: LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4·N payload bytes (byte 0 is bits 7:0 of each word), then one checksum byte when BOOT_CHECKSUM_EN is defined.
- States: IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERROR.
- IDLE/DONE/ERROR --start--> LEN_LO; clears done, error, core_enable, word index, byte count, checksum.
- LEN_LO --byte--> LEN_HI --byte--> DATA if 0 < N ≤ 2**ADDR_WIDTH; CHECK (or DONE without the macro) if N = 0; ERROR if N > 2**ADDR_WIDTH.
- DATA: 2-bit byte counter; on the 4th accepted byte, the word is written at the current index and the index increments. After word N-1 → CHECK (or DONE).
- CHECK --byte--> DONE if the byte equals the XOR of all payload bytes, else ERROR.
- A byte is accepted when s_valid && s_ready at the rising edge; s_ready = 1 only in LEN_LO, LEN_HI, DATA, CHECK.
- start is ignored while busy. s_data/s_valid are ignored outside the accepting states.
- core_enable = 1 only in DONE; it stays high until the next start or rst.
- Reset mid-session: all outputs are forced to their reset values on the next edge. Any partial word is discarded, and words already written stay in memory.

## Timing
- Reset values: s_ready 0, mem_we 0, mem_addr 0, mem_wdata 0, core_enable 0, busy 0, done 0, error 0; state IDLE.
- All outputs are registered. s_ready rises the cycle after start is sampled.
- mem_we pulses in the cycle after the 4th byte of a word is accepted, with mem_addr and mem_wdata valid in that same cycle.
- Final word: mem_we pulses in the same cycle the state enters CHECK (or DONE).
- done, error and core_enable rise the cycle after the deciding byte is accepted.
- Zero-bubble: back-to-back bytes are accepted every cycle. Throughput is one word per 4 cycles.
- The word index wraps never; the N bound check guarantees index ≤ 2**ADDR_WIDTH-1.

## Configuration
- BOOT_CHECKSUM_EN: when defined, a CHECK state is included and a trailing XOR checksum byte is required; a mismatch goes to ERROR with core_enable held 0.
- When undefined, CHECK is not compiled. The state goes from DATA (or LEN_HI with N = 0) straight to DONE, and error is raised only on an oversize N.

## Structure
- Shared package hisoc_boot_pkg holds:
  - the state enum;
  - the header length constant (2 bytes);
  - the word-bytes constant (4).
- Sub-module hisoc_boot_pack is the byte-to-word packer: 2-bit counter, 32-bit shift register, word-valid pulse. The FSM, the word index and the checksum stay in the top module.

## Test plan
- rst held 3 cycles, mid-stream → all outputs 0, state IDLE, and a new start boots cleanly afterwards.
- start, then bytes 02 00 | 13 00 00 00 | 6F 00 00 00 | checksum 7C → writes 0x00000013 at 0 and 0x0000006F at 1; done=1 and core_enable=1 one cycle after the checksum byte.
- Same frame with checksum 00 → error=1, core_enable=0; words are still written.
- Header 00 00, then checksum 00 → no mem_we; done=1.
- ADDR_WIDTH=4, header 11 00 (N=17) → ERROR after LEN_HI, s_ready=0, no mem_we.
- s_valid toggling 1/0 every cycle during a 3-word payload → exactly 3 mem_we pulses, each 8 cycles apart, with correct words. start pulsed while busy has no effect.
